// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter using shift-and-add-3
// (double dabble), one input bit per clock.
//
// Ports:
//   clk       system clock, rising edge
//   reset_p   asynchronous active-high reset
//   start     conversion request, accepted only while busy=0
//   bin       value to convert, sampled on the accepted start edge
//   busy      high while a conversion is in progress
//   done      one-cycle pulse marking new results on bcd/sign/overflow
//   bcd       packed BCD result, digit 0 in [3:0], held until next done
//   sign      input was negative (SIGNED=1 only), updated with done
//   overflow  magnitude exceeded 10^DIGITS-1, updated with done
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4,
    parameter int unsigned SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  sign,
    output logic                  overflow
);

    localparam int unsigned BCD_W = DIGITS * 4;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    // Parameter range guard at elaboration.
    if (BIN_W < 2 || BIN_W > 32) begin : g_bad_bin_w
        $error("bin_to_bcd_seq: BIN_W out of range 2..32");
    end
    if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS out of range 1..10");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               busy_d, done_d, sign_d, overflow_d;
    logic [BCD_W-1:0]   bcd_d;

    // Datapath helpers.
    logic               neg_in;
    logic [BIN_W-1:0]   mag;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scratch_sh;
    logic [BIN_W-1:0]   shreg_sh;
    logic               carry;

    // Magnitude of the input; two's-complement negate keeps BIN_W bits so
    // the most negative value maps to 2^(BIN_W-1).
    always_comb begin
        neg_in = (SIGNED != 0) && bin[BIN_W-1];
        mag    = neg_in ? (~bin) + BIN_W'(1) : bin;
    end

    // Per-digit add-3 correction, then one-bit left shift of {scratch, shreg}.
    always_comb begin
        adj = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            adj[i*4 +: 4] = (scratch_q[i*4 +: 4] >= 4'd5) ? scratch_q[i*4 +: 4] + 4'd3
                                                           : scratch_q[i*4 +: 4];
        end
        {carry, scratch_sh} = {adj, shreg_q[BIN_W-1]};
        shreg_sh            = {shreg_q[BIN_W-2:0], 1'b0};
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            sign      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            busy      <= busy_d;
            done      <= done_d;
            bcd       <= bcd_d;
            sign      <= sign_d;
            overflow  <= overflow_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        busy_d     = busy;
        done_d     = 1'b0;
        bcd_d      = bcd;
        sign_d     = sign;
        overflow_d = overflow;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = mag;
                    neg_d     = neg_in;
                    scratch_d = '0;
                    ovf_d     = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d   = shreg_sh;
                scratch_d = scratch_sh;
                ovf_d     = ovf_q | carry;
                cnt_d     = cnt_q - CNT_W'(1);
                // Last bit: publish results and return to idle.
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d      = scratch_sh;
                    sign_d     = neg_q;
                    overflow_d = ovf_q | carry;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for bin_to_bcd_seq in three
// configurations (12b/4d unsigned, 10b/3d unsigned, 12b/4d signed).
module tb_bin_to_bcd_seq;

    typedef struct {
        logic [63:0] bcd;
        logic        sign;
        logic        ovf;
        int          t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;

    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [11:0] bin_a = '0, bin_c = '0;
    logic [9:0]  bin_b = '0;
    logic        busy_a, done_a, sign_a, ovf_a;
    logic        busy_b, done_b, sign_b, ovf_b;
    logic        busy_c, done_c, sign_c, ovf_c;
    logic [15:0] bcd_a, bcd_c;
    logic [11:0] bcd_b;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t q_a[$], q_b[$], q_c[$];
    exp_t ea, eb, ec;
    logic prev_done_a = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(0)) u_a (
        .clk(clk), .reset_p(reset_p), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .sign(sign_a), .overflow(ovf_a));

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3), .SIGNED(0)) u_b (
        .clk(clk), .reset_p(reset_p), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .sign(sign_b), .overflow(ovf_b));

    bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(1)) u_c (
        .clk(clk), .reset_p(reset_p), .start(start_c), .bin(bin_c),
        .busy(busy_c), .done(done_c), .bcd(bcd_c), .sign(sign_c), .overflow(ovf_c));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: decimal digits by repeated division.
    function automatic logic [63:0] bcd_of(input longint unsigned v, input int digits);
        logic [63:0] r = '0;
        for (int i = 0; i < digits; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic longint unsigned pow10(input int digits);
        longint unsigned p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return p;
    endfunction

    // Issue a start pulse (call at a negedge) and push the expected result.
    task automatic go_a(input logic [11:0] v);
        exp_t e;
        start_a = 1'b1;
        bin_a   = v;
        e.bcd   = bcd_of(longint'(v), 4);
        e.ovf   = longint'(v) >= pow10(4);
        e.sign  = 1'b0;
        e.t0    = cyc + 1;
        q_a.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic go_b(input logic [9:0] v);
        exp_t e;
        start_b = 1'b1;
        bin_b   = v;
        e.bcd   = bcd_of(longint'(v), 3);
        e.ovf   = longint'(v) >= pow10(3);
        e.sign  = 1'b0;
        e.t0    = cyc + 1;
        q_b.push_back(e);
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic go_c(input logic [11:0] v);
        exp_t e;
        longint unsigned m;
        m       = v[11] ? 64'd4096 - longint'(v) : longint'(v);
        start_c = 1'b1;
        bin_c   = v;
        e.bcd   = bcd_of(m, 4);
        e.ovf   = m >= pow10(4);
        e.sign  = v[11];
        e.t0    = cyc + 1;
        q_c.push_back(e);
        @(negedge clk);
        start_c = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ((q_a.size() + q_b.size() + q_c.size()) != 0) begin
            check("result_timeout", 64'(q_a.size() + q_b.size() + q_c.size()), 64'd0);
            q_a.delete(); q_b.delete(); q_c.delete();
        end
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!done_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done_a) check("a_done_timeout", 64'd0, 64'd1);
    endtask

    // Output monitors: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (!reset_p) begin
            if (done_a && prev_done_a) check("a_done_width", 64'd2, 64'd1);
            if (done_a) begin
                if (q_a.size() == 0) check("a_spurious_done", 64'd1, 64'd0);
                else begin
                    ea = q_a.pop_front();
                    check("a_bcd", 64'(bcd_a), ea.bcd);
                    check("a_sign", 64'(sign_a), 64'(ea.sign));
                    check("a_ovf", 64'(ovf_a), 64'(ea.ovf));
                    check("a_latency", 64'(cyc - ea.t0), 64'd12);
                    check("a_busy_at_done", 64'(busy_a), 64'd0);
                end
            end
            if (done_b) begin
                if (q_b.size() == 0) check("b_spurious_done", 64'd1, 64'd0);
                else begin
                    eb = q_b.pop_front();
                    check("b_bcd", 64'(bcd_b), eb.bcd);
                    check("b_ovf", 64'(ovf_b), 64'(eb.ovf));
                    check("b_sign", 64'(sign_b), 64'(eb.sign));
                    check("b_latency", 64'(cyc - eb.t0), 64'd10);
                end
            end
            if (done_c) begin
                if (q_c.size() == 0) check("c_spurious_done", 64'd1, 64'd0);
                else begin
                    ec = q_c.pop_front();
                    check("c_bcd", 64'(bcd_c), ec.bcd);
                    check("c_sign", 64'(sign_c), 64'(ec.sign));
                    check("c_ovf", 64'(ovf_c), 64'(ec.ovf));
                    check("c_latency", 64'(cyc - ec.t0), 64'd12);
                end
            end
        end
        prev_done_a <= done_a;
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_bcd", 64'(bcd_a), 64'd0);
        check("rst_ovf", 64'(ovf_a), 64'd0);
        check("rst_sign_c", 64'(sign_c), 64'd0);
        reset_p = 1'b0;
        @(negedge clk);

        // Full-scale unsigned value.
        go_a(12'd4095);
        wait_empty(40);

        // Zero, then back-to-back starts issued in the done cycle.
        go_a(12'd0);
        wait_done_a(40);
        go_a(12'd999);
        wait_done_a(40);
        go_a(12'd1234);
        wait_empty(40);

        // Overflow boundary on the 3-digit instance; flag must clear.
        go_b(10'd1000);
        wait_empty(40);
        go_b(10'd999);
        wait_empty(40);
        go_b(10'd1023);
        wait_empty(40);

        // Signed inputs including the most negative value.
        go_c(12'hFFF);
        wait_empty(40);
        go_c(12'h800);
        wait_empty(40);
        go_c(12'h7FF);
        wait_empty(40);
        go_c(12'h000);
        wait_empty(40);

        // Start pulsed mid-conversion with different data is ignored.
        go_a(12'd321);
        repeat (4) @(negedge clk);
        start_a = 1'b1;
        bin_a   = 12'd777;
        @(negedge clk);
        start_a = 1'b0;
        wait_empty(40);
        repeat (20) @(negedge clk);
        check("a_hold_after_ignore", 64'(bcd_a), 64'h0321);
        check("a_idle_after_ignore", 64'(busy_a), 64'd0);

        // Asynchronous reset in the middle of a conversion.
        go_a(12'd555);
        repeat (5) @(negedge clk);
        #1 reset_p = 1'b1;
        #1;
        check("abort_busy", 64'(busy_a), 64'd0);
        check("abort_done", 64'(done_a), 64'd0);
        check("abort_bcd", 64'(bcd_a), 64'd0);
        check("abort_sign", 64'(sign_a), 64'd0);
        check("abort_ovf", 64'(ovf_a), 64'd0);
        q_a.delete();
        @(negedge clk);
        @(negedge clk);
        reset_p = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done_bcd", 64'(bcd_a), 64'd0);
        go_a(12'd2024);
        wait_empty(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
